fe2_mul_rr_arbiter: RTL and testbench
=====================================

// Module: fe2_mul_rr_arbiter
// PURPOSE
//  Shares one Fp2 multiplier between NUM_IN requesters (pairing engine, G2 point ops, Fp12 tower).
//  - Request side: round-robin arbitration, packet-locked (sop..eop).
//  - Each accepted beat is tagged with the requester index in its ctl field.
//  - Results return on a single stream and are steered back to the owning requester by that tag.
//  - Sits between requester if_axi_stream ports and the shared ewise/karatsuba Fp2 multiplier.
// PARAMETERS
//  NUM_IN      4     number of requesters (2..16)
//  DAT_BITS    1524  request data width (two fe2_t operands)
//  RES_BITS    762   result data width (one fe2_t)
//  CTL_BITS    32    ctl width, passed through unchanged except the ID field
//  OVR_WRT_BIT 24    LSB of the ID field, ID_BITS=$clog2(NUM_IN); requesters must not use these bits
// PORTS
//  i_clk       in   1                  clock
//  i_rst       in   1                  synchronous active-high reset
//  i_req_val   in   NUM_IN             per-requester valid
//  o_req_rdy   out  NUM_IN             per-requester ready
//  i_req_dat   in   NUM_IN*DAT_BITS    requester i occupies [i*DAT_BITS +: DAT_BITS]
//  i_req_ctl   in   NUM_IN*CTL_BITS    per-requester ctl
//  i_req_sop   in   NUM_IN             per-requester start of packet
//  i_req_eop   in   NUM_IN             per-requester end of packet
//  o_mul_val   out  1                  to multiplier: valid (registered)
//  i_mul_rdy   in   1                  from multiplier: ready
//  o_mul_dat   out  DAT_BITS           operands
//  o_mul_ctl   out  CTL_BITS           ctl with ID field overwritten
//  o_mul_sop   out  1                  start of packet
//  o_mul_eop   out  1                  end of packet
//  i_res_val   in   1                  from multiplier: result valid
//  o_res_rdy   out  1                  to multiplier: result ready
//  i_res_dat   in   RES_BITS           result
//  i_res_ctl   in   CTL_BITS           result ctl carrying ID
//  o_rsp_val   out  NUM_IN             per-requester result valid
//  i_rsp_rdy   in   NUM_IN             per-requester result ready
//  o_rsp_dat   out  RES_BITS           result data, broadcast to all requesters
//  o_rsp_ctl   out  CTL_BITS           result ctl, broadcast, ID field left intact
// BEHAVIOUR
//  Reset:
//   - o_mul_val=0, o_mul_sop/eop/dat/ctl=0, state=IDLE, rr pointer=0, grant=0.
//   - o_req_rdy=0 during reset.
//  Output register:
//   - Single stage; slot is free when !o_mul_val || i_mul_rdy.
//   - Latency: accepted beat appears on o_mul_* the next cycle. Full throughput, 1 beat/cycle.
//  Arbitration:
//   - Candidate = first i with i_req_val[i], scanning ptr, ptr+1, ... modulo NUM_IN.
//   - o_req_rdy[i] = (i==cand) && slot free && !i_rst; all other bits 0.
//  FSM IDLE:
//   - On accept with eop=1: stay IDLE, ptr <= cand+1 (mod NUM_IN).
//   - On accept with eop=0: grant <= cand, go LOCK.
//  FSM LOCK:
//   - Only the grant requester is eligible; others stall even if valid.
//   - On accept with eop=1: go IDLE, ptr <= grant+1 (mod NUM_IN).
//  Tagging:
//   - o_mul_ctl = i_req_ctl[g] with [OVR_WRT_BIT +: ID_BITS] replaced by g.
//   - dat/sop/eop copied unchanged.
//  Response demux (combinational, stateless):
//   - id = i_res_ctl[OVR_WRT_BIT +: ID_BITS].
//   - o_rsp_val[id] = i_res_val; o_res_rdy = i_rsp_rdy[id].
//   - id >= NUM_IN: beat is dropped (o_res_rdy=1, no o_rsp_val asserted).
//  Boundaries:
//   - No requester valid: nothing accepted; o_mul_val falls after its current beat drains.
//   - i_mul_rdy=0 with o_mul_val=1: o_mul_* hold stable, all o_req_rdy=0.
//   - Simultaneous request accept and result return are independent and both proceed.
//   - Reset mid-packet: LOCK abandoned, buffered beat discarded.
//     Results already inside the multiplier are still routed by ID (demux is stateless).
// TESTING
//  1. Requester 2 only, single-beat packets, a=G2x, b=G2y:
//     o_mul_val 1 cycle later, o_mul_ctl ID=2, result returns on o_rsp_val[2] only.
//  2. All 4 valid continuously, eop=1, i_mul_rdy=1: grant order 0,1,2,3,0,1,...
//     Exactly 1 beat/cycle, no bubbles.
//  3. Req0 3-beat packet (eop on beat 3) while req1 valid:
//     req1 blocked until req0 eop accepted, then req1 granted next.
//  4. i_mul_rdy toggled randomly 50%, 1000 beats from random requesters:
//     no beat lost or duplicated. Scoreboard per requester; results match the bls12_381_pkg fe2_mul model.
//  5. Result with ID=1 and i_rsp_rdy[1]=0, i_rsp_rdy[0]=1: o_res_rdy=0, beat held.
//     With NUM_IN=3, a result with ID=3 is dropped with o_res_rdy=1.
//  6. Assert i_rst for 1 cycle mid-LOCK with o_mul_val=1:
//     next cycle o_mul_val=0, state IDLE, ptr=0, arbitration restarts at requester 0.

Source files
------------

// File: rtl/fe2_mul_rr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one Fp2 multiplier among NUM_IN requesters.
// Latency 1 cycle request->o_mul_*; result steering is combinational; o_req_rdy drops while the output slot is held.
module fe2_mul_rr_arbiter #(
    parameter int NUM_IN      = 4,
    parameter int DAT_BITS    = 1524,
    parameter int RES_BITS    = 762,
    parameter int CTL_BITS    = 32,
    parameter int OVR_WRT_BIT = 24
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_IN-1:0]            i_req_val,
    output logic [NUM_IN-1:0]            o_req_rdy,
    input  logic [NUM_IN*DAT_BITS-1:0]   i_req_dat,
    input  logic [NUM_IN*CTL_BITS-1:0]   i_req_ctl,
    input  logic [NUM_IN-1:0]            i_req_sop,
    input  logic [NUM_IN-1:0]            i_req_eop,
    output logic                         o_mul_val,
    input  logic                         i_mul_rdy,
    output logic [DAT_BITS-1:0]          o_mul_dat,
    output logic [CTL_BITS-1:0]          o_mul_ctl,
    output logic                         o_mul_sop,
    output logic                         o_mul_eop,
    input  logic                         i_res_val,
    output logic                         o_res_rdy,
    input  logic [RES_BITS-1:0]          i_res_dat,
    input  logic [CTL_BITS-1:0]          i_res_ctl,
    output logic [NUM_IN-1:0]            o_rsp_val,
    input  logic [NUM_IN-1:0]            i_rsp_rdy,
    output logic [RES_BITS-1:0]          o_rsp_dat,
    output logic [CTL_BITS-1:0]          o_rsp_ctl
);
    localparam int ID_BITS = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {S_IDLE, S_LOCK} state_t;

    state_t               r_state, w_state_nxt;
    logic [ID_BITS-1:0]   r_ptr, w_ptr_nxt;
    logic [ID_BITS-1:0]   r_grant, w_grant_nxt;
    logic                 r_mul_val, r_mul_sop, r_mul_eop;
    logic [DAT_BITS-1:0]  r_mul_dat;
    logic [CTL_BITS-1:0]  r_mul_ctl;

    logic [ID_BITS-1:0]   w_cand;
    logic                 w_cand_vld;
    logic                 w_slot_free;
    logic                 w_acc;
    logic                 w_acc_eop;
    logic [DAT_BITS-1:0]  w_sel_dat;
    logic [CTL_BITS-1:0]  w_tag_ctl;
    logic [NUM_IN-1:0]    w_req_rdy;
    logic [ID_BITS-1:0]   w_res_id;
    logic                 w_id_ok;
    logic [NUM_IN-1:0]    w_rsp_val;

    function automatic logic [ID_BITS-1:0] f_inc(input logic [ID_BITS-1:0] v);
        return (int'(v) == NUM_IN - 1) ? '0 : v + 1'b1;
    endfunction

    // In LOCK the grant owner is the only candidate, valid or not.
    always_comb begin
        logic [ID_BITS:0] v_idx;
        w_cand     = '0;
        w_cand_vld = 1'b0;
        v_idx      = '0;
        if (r_state == S_LOCK) begin
            w_cand     = r_grant;
            w_cand_vld = 1'b1;
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                v_idx = {1'b0, r_ptr} + (ID_BITS+1)'(k);
                if (v_idx >= (ID_BITS+1)'(NUM_IN))
                    v_idx = v_idx - (ID_BITS+1)'(NUM_IN);
                if (!w_cand_vld && i_req_val[v_idx[ID_BITS-1:0]]) begin
                    w_cand     = v_idx[ID_BITS-1:0];
                    w_cand_vld = 1'b1;
                end
            end
        end
    end

    assign w_slot_free = !r_mul_val || i_mul_rdy;
    assign w_acc       = w_cand_vld && i_req_val[w_cand] && w_slot_free && !i_rst;
    assign w_acc_eop   = i_req_eop[w_cand];
    assign w_sel_dat   = i_req_dat[int'(w_cand)*DAT_BITS +: DAT_BITS];

    always_comb begin
        w_tag_ctl = i_req_ctl[int'(w_cand)*CTL_BITS +: CTL_BITS];
        w_tag_ctl[OVR_WRT_BIT +: ID_BITS] = w_cand;
    end

    always_comb begin
        w_req_rdy = '0;
        if (w_cand_vld && w_slot_free && !i_rst)
            w_req_rdy[w_cand] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        if (w_acc) begin
            if (r_state == S_IDLE) begin
                if (w_acc_eop) begin
                    w_ptr_nxt = f_inc(w_cand);
                end else begin
                    w_grant_nxt = w_cand;
                    w_state_nxt = S_LOCK;
                end
            end else if (w_acc_eop) begin
                w_state_nxt = S_IDLE;
                w_ptr_nxt   = f_inc(r_grant);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_mul_val <= 1'b0;
            r_mul_sop <= 1'b0;
            r_mul_eop <= 1'b0;
            r_mul_dat <= '0;
            r_mul_ctl <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            if (w_slot_free) begin
                r_mul_val <= w_acc;
                if (w_acc) begin
                    r_mul_dat <= w_sel_dat;
                    r_mul_ctl <= w_tag_ctl;
                    r_mul_sop <= i_req_sop[w_cand];
                    r_mul_eop <= w_acc_eop;
                end
            end
        end
    end

    // Results with an out-of-range ID are consumed so the multiplier never wedges.
    assign w_res_id = i_res_ctl[OVR_WRT_BIT +: ID_BITS];
    assign w_id_ok  = ({1'b0, w_res_id} < (ID_BITS+1)'(NUM_IN));

    always_comb begin
        w_rsp_val = '0;
        if (w_id_ok)
            w_rsp_val[w_res_id] = i_res_val;
    end

    assign o_req_rdy = w_req_rdy;
    assign o_mul_val = r_mul_val;
    assign o_mul_dat = r_mul_dat;
    assign o_mul_ctl = r_mul_ctl;
    assign o_mul_sop = r_mul_sop;
    assign o_mul_eop = r_mul_eop;
    assign o_rsp_val = w_rsp_val;
    assign o_res_rdy = w_id_ok ? i_rsp_rdy[w_res_id] : 1'b1;
    assign o_rsp_dat = i_res_dat;
    assign o_rsp_ctl = i_res_ctl;
endmodule

// File: tb/tb_fe2_mul_rr_arbiter.sv
// Directed-vector and randomised-traffic bench for fe2_mul_rr_arbiter (4-way and 3-way instances).
module tb_fe2_mul_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int RW = 8;
    localparam int CW = 32;
    localparam int OB = 24;
    localparam int NB = 250;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N-1:0]      req_val, req_rdy, req_sop, req_eop;
    logic [DW-1:0]     rdat [N];
    logic [CW-1:0]     rctl [N];
    logic [N*DW-1:0]   req_dat_f;
    logic [N*CW-1:0]   req_ctl_f;
    logic              mul_val, mul_rdy, mul_sop, mul_eop;
    logic [DW-1:0]     mul_dat;
    logic [CW-1:0]     mul_ctl;
    logic              res_val, res_rdy;
    logic [RW-1:0]     res_dat;
    logic [CW-1:0]     res_ctl;
    logic [N-1:0]      rsp_val, rsp_rdy;
    logic [RW-1:0]     rsp_dat;
    logic [CW-1:0]     rsp_ctl;

    logic [2:0]        req_rdy3, rsp_val3;
    logic              mul_val3, mul_sop3, mul_eop3, res_rdy3;
    logic [DW-1:0]     mul_dat3;
    logic [CW-1:0]     mul_ctl3, rsp_ctl3;
    logic [RW-1:0]     rsp_dat3;

    int n_cmp = 0;
    int n_err = 0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_dat_f[i*DW +: DW] = rdat[i];
            req_ctl_f[i*CW +: CW] = rctl[i];
        end
    end

    fe2_mul_rr_arbiter #(.NUM_IN(N), .DAT_BITS(DW), .RES_BITS(RW), .CTL_BITS(CW), .OVR_WRT_BIT(OB)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_val(req_val), .o_req_rdy(req_rdy), .i_req_dat(req_dat_f), .i_req_ctl(req_ctl_f),
        .i_req_sop(req_sop), .i_req_eop(req_eop),
        .o_mul_val(mul_val), .i_mul_rdy(mul_rdy), .o_mul_dat(mul_dat), .o_mul_ctl(mul_ctl),
        .o_mul_sop(mul_sop), .o_mul_eop(mul_eop),
        .i_res_val(res_val), .o_res_rdy(res_rdy), .i_res_dat(res_dat), .i_res_ctl(res_ctl),
        .o_rsp_val(rsp_val), .i_rsp_rdy(rsp_rdy), .o_rsp_dat(rsp_dat), .o_rsp_ctl(rsp_ctl)
    );

    fe2_mul_rr_arbiter #(.NUM_IN(3), .DAT_BITS(DW), .RES_BITS(RW), .CTL_BITS(CW), .OVR_WRT_BIT(OB)) u_dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_req_val(3'b000), .o_req_rdy(req_rdy3), .i_req_dat({3*DW{1'b0}}), .i_req_ctl({3*CW{1'b0}}),
        .i_req_sop(3'b000), .i_req_eop(3'b000),
        .o_mul_val(mul_val3), .i_mul_rdy(1'b1), .o_mul_dat(mul_dat3), .o_mul_ctl(mul_ctl3),
        .o_mul_sop(mul_sop3), .o_mul_eop(mul_eop3),
        .i_res_val(res_val), .o_res_rdy(res_rdy3), .i_res_dat(res_dat), .i_res_ctl(res_ctl),
        .o_rsp_val(rsp_val3), .i_rsp_rdy(rsp_rdy[2:0]), .o_rsp_dat(rsp_dat3), .o_rsp_ctl(rsp_ctl3)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] fmod(input logic [DW-1:0] d);
        return d[7:0] ^ d[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [CW-1:0] exp_ctl(input int g);
        return 32'h0000_0F00 | 32'(g) | (32'(g) << OB);
    endfunction

    typedef struct {
        logic [N-1:0] val;
        logic [N-1:0] eop;
        logic         mrdy;
        logic [N-1:0] exp_rdy;
        logic         exp_mval;
        logic [1:0]   exp_id;
    } vec_t;

    typedef struct {
        logic         rv;
        logic [1:0]   id;
        logic [N-1:0] rr;
        logic [N-1:0] exp_v4;
        logic         exp_r4;
        logic [2:0]   exp_v3;
        logic         exp_r3;
    } dvec_t;

    vec_t  vt [15];
    dvec_t dt [5];

    int          sent [N];
    int          mexp [N];
    int          rcnt [N];
    logic [DW-1:0] res_q [$];
    logic [N-1:0]  acc;
    logic          lock_act;
    logic [1:0]    lock_id, g;
    int            cyc;
    bit            done;

    initial begin
        // val, eop, mul_rdy, exp_rdy, exp_mul_val, exp_id
        vt[0]  = '{4'b0100, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        vt[1]  = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
        vt[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        vt[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vt[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        vt[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        vt[6]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        vt[7]  = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
        vt[8]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vt[9]  = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0};
        vt[10] = '{4'b0010, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0};
        vt[11] = '{4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0};
        vt[12] = '{4'b0011, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
        vt[13] = '{4'b0010, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        vt[14] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
        // res_val, id, rsp_rdy, exp rsp_val/res_rdy for N=4, then for N=3
        dt[0] = '{1'b1, 2'd2, 4'b1111, 4'b0100, 1'b1, 3'b100, 1'b1};
        dt[1] = '{1'b1, 2'd1, 4'b0001, 4'b0010, 1'b0, 3'b010, 1'b0};
        dt[2] = '{1'b0, 2'd1, 4'b0010, 4'b0000, 1'b1, 3'b000, 1'b1};
        dt[3] = '{1'b1, 2'd3, 4'b0000, 4'b1000, 1'b0, 3'b000, 1'b1};
        dt[4] = '{1'b1, 2'd0, 4'b1110, 4'b0001, 1'b0, 3'b001, 1'b0};

        rst = 1'b1;
        req_val = '1; req_sop = '1; req_eop = '1; mul_rdy = 1'b1;
        res_val = 1'b0; res_dat = '0; res_ctl = '0; rsp_rdy = '0;
        for (int i = 0; i < N; i++) begin
            rdat[i] = 16'hD000 | 16'(i);
            rctl[i] = 32'h0300_0F00 | 32'(i);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_rdy", req_rdy, 4'b0000);
        chk("reset_mul_val", mul_val, 1'b0);
        chk("reset_mul_dat", mul_dat, 16'h0);
        chk("reset_mul_ctl", mul_ctl, 32'h0);
        rst = 1'b0;
        req_val = '0;

        for (int r = 0; r < 15; r++) begin
            req_val = vt[r].val;
            req_eop = vt[r].eop;
            mul_rdy = vt[r].mrdy;
            #1;
            chk($sformatf("vec%0d_req_rdy", r), req_rdy, vt[r].exp_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_mul_val", r), mul_val, vt[r].exp_mval);
            if (vt[r].exp_mval) begin
                chk($sformatf("vec%0d_mul_ctl", r), mul_ctl, exp_ctl(int'(vt[r].exp_id)));
                chk($sformatf("vec%0d_mul_dat", r), mul_dat, 16'hD000 | 16'(vt[r].exp_id));
            end
        end

        // Reset mid-LOCK while the output slot is held
        req_val = 4'b1000; req_eop = 4'b0000; mul_rdy = 1'b0;
        #1;
        chk("lock_start_rdy", req_rdy, 4'b1000);
        @(posedge clk); #1;
        chk("lock_start_val", mul_val, 1'b1);
        rst = 1'b1; req_val = 4'b1111;
        #1;
        chk("rst_req_rdy", req_rdy, 4'b0000);
        @(posedge clk); #1;
        chk("rst_mul_val", mul_val, 1'b0);
        chk("rst_mul_ctl", mul_ctl, 32'h0);
        rst = 1'b0; req_eop = 4'b1111; mul_rdy = 1'b1;
        #1;
        chk("post_rst_rdy", req_rdy, 4'b0001);
        @(posedge clk); #1;
        chk("post_rst_ctl", mul_ctl, exp_ctl(0));
        req_val = '0;
        @(posedge clk); #1;

        for (int r = 0; r < 5; r++) begin
            res_val = dt[r].rv;
            res_ctl = 32'hC0AB_CD12 | (32'(dt[r].id) << OB);
            res_dat = 8'h3C ^ 8'(r);
            rsp_rdy = dt[r].rr;
            #1;
            chk($sformatf("dmx%0d_rsp_val", r), rsp_val, dt[r].exp_v4);
            chk($sformatf("dmx%0d_res_rdy", r), res_rdy, dt[r].exp_r4);
            chk($sformatf("dmx%0d_rsp_val3", r), rsp_val3, dt[r].exp_v3);
            chk($sformatf("dmx%0d_res_rdy3", r), res_rdy3, dt[r].exp_r3);
            chk($sformatf("dmx%0d_rsp_ctl", r), rsp_ctl, res_ctl);
            chk($sformatf("dmx%0d_rsp_dat", r), rsp_dat, 8'h3C ^ 8'(r));
        end
        res_val = 1'b0;
        @(posedge clk); #1;

        // Randomised traffic with a loop-back multiplier model
        for (int r = 0; r < N; r++) begin
            sent[r] = 0; mexp[r] = 0; rcnt[r] = 0;
        end
        lock_act = 1'b0; lock_id = '0; cyc = 0; done = 1'b0;
        while (!done && cyc < 20000) begin
            for (int r = 0; r < N; r++) begin
                if (!req_val[r] && sent[r] < NB && $urandom_range(0, 1) == 1) begin
                    rdat[r]    = {4'(r), 12'(sent[r])};
                    req_eop[r] = ((sent[r] + r) % 3 == 2) || (sent[r] == NB - 1);
                    req_val[r] = 1'b1;
                end
            end
            mul_rdy = 1'($urandom_range(0, 1));
            if (res_q.size() > 0) begin
                res_val = 1'b1;
                res_dat = fmod(res_q[0]);
                res_ctl = 32'h0000_00A5 | (32'(res_q[0][15:12]) << OB);
            end else begin
                res_val = 1'b0;
            end
            rsp_rdy = 4'($urandom_range(0, 15));
            #1;
            acc = req_val & req_rdy;
            if (mul_val && mul_rdy) begin
                g = mul_ctl[OB +: 2];
                chk("rnd_id_vs_dat", mul_dat[15:12], 4'(g));
                chk("rnd_seq", mul_dat[11:0], 12'(mexp[g]));
                if (lock_act) chk("rnd_lock", g, lock_id);
                mexp[g]++;
                lock_act = !mul_eop;
                lock_id  = g;
                res_q.push_back(mul_dat);
            end
            if (res_val && res_rdy) begin
                g = res_ctl[OB +: 2];
                chk("rnd_rsp_val", rsp_val, 4'b0001 << g);
                chk("rnd_rsp_dat", rsp_dat, fmod({4'(g), 12'(rcnt[g])}));
                rcnt[g]++;
                void'(res_q.pop_front());
            end
            @(posedge clk); #1;
            for (int r = 0; r < N; r++) begin
                if (acc[r]) begin
                    sent[r]++;
                    req_val[r] = 1'b0;
                end
            end
            done = 1'b1;
            for (int r = 0; r < N; r++)
                if (rcnt[r] < NB) done = 1'b0;
            cyc++;
        end
        for (int r = 0; r < N; r++) begin
            chk($sformatf("rnd_beats_req%0d", r), 64'(mexp[r]), 64'(NB));
            chk($sformatf("rnd_results_req%0d", r), 64'(rcnt[r]), 64'(NB));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
